pcie_tl_cpl_splitter: RTL and testbench

Completion scheduler for the PCIe transaction layer. It takes one Memory Read request descriptor (decoded from a `tlp_memory_req_hdr_t`) and emits the ordered sequence of Completion-with-Data descriptors that answers it. Each descriptor carries the fields a downstream header builder needs for a `tlp_cpl_hdr_t`. Splitting follows the Max Payload Size (MPS) and Read Completion Boundary (RCB) rules: ascending addresses, first completion starts at the request address, intermediate completions end on RCB boundaries, and payloads sum to the requested size. It sits between the inbound non-posted request path and the completion header generator / data mover.

---
 rtl/pcie_tl_cpl_splitter.sv | 269 ++++++++++++++++++++++++++
 tb/tb_pcie_tl_cpl_splitter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_tl_cpl_splitter.sv
// pcie_tl_cpl_splitter: turns one Memory Read request descriptor into
// the ordered Completion-with-Data descriptors that answer it.
//
// Parameters:
//   MPS_BYTES  max payload per completion (power of 2, 128..4096)
//   RCB_BYTES  read completion boundary (64 or 128, <= MPS_BYTES)
// Ports:
//   clk, rst            single clock, async active-high reset
//   req_valid/ready     request handshake (ready only when idle)
//   req_addr            request byte address, bits [1:0] ignored
//   req_length          length in DW, 0 = 1024
//   req_first_be/last_be  first/last DW byte enables
//   req_tag, req_requester_id, req_tc, req_attr  copied to completions
//   cpl_valid/ready     completion descriptor handshake
//   cpl_length          payload in DW, 0 = 1024
//   cpl_byte_cnt        remaining bytes incl. this one, 0 = 4096
//   cpl_lower_addr      low address bits of this completion's first byte
//   cpl_dw_offset       DW offset of this payload from the request start
//   cpl_tag, cpl_requester_id, cpl_tc, cpl_attr  request copies
//   cpl_last            final completion of the request
//   busy                block is not idle

module pcie_tl_cpl_splitter #(
  parameter int MPS_BYTES = 256,
  parameter int RCB_BYTES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic [9:0]  req_length,
  input  logic [3:0]  req_first_be,
  input  logic [3:0]  req_last_be,
  input  logic [9:0]  req_tag,
  input  logic [15:0] req_requester_id,
  input  logic [2:0]  req_tc,
  input  logic [2:0]  req_attr,
  output logic        cpl_valid,
  input  logic        cpl_ready,
  output logic [9:0]  cpl_length,
  output logic [11:0] cpl_byte_cnt,
  output logic [6:0]  cpl_lower_addr,
  output logic [9:0]  cpl_dw_offset,
  output logic [9:0]  cpl_tag,
  output logic [15:0] cpl_requester_id,
  output logic [2:0]  cpl_tc,
  output logic [2:0]  cpl_attr,
  output logic        cpl_last,
  output logic        busy
);

  localparam logic [10:0] MPS_DW = 11'(MPS_BYTES / 4);
  localparam logic [4:0] RCB_MASK = 5'(RCB_BYTES / 4 - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    EMIT
  } state_t;

  state_t state;
  state_t state_nxt;

  // latched request
  logic [61:0] a_dw;
  logic [9:0]  a_len;
  logic [3:0]  a_fbe;
  logic [3:0]  a_lbe;

  // walking state of the completion currently on the outputs
  logic [61:0] cur_dw;
  logic [10:0] rem_dw;
  logic [12:0] rb;
  logic [9:0]  off_dw;
  logic [10:0] chunk_r;
  logic [1:0]  fo_r;
  logic        first;

  // request-derived values used in CALC
  logic [1:0]  fo_c;
  logic [1:0]  lt_c;
  logic [10:0] len_dw;
  logic [12:0] tb_c;
  logic [10:0] chunk0;

  // next completion after a non-final handshake
  logic [61:0] n_cur;
  logic [10:0] n_rem;
  logic [12:0] n_rb;
  logic [9:0]  n_off;
  logic [10:0] n_chunk;
  logic [12:0] n_sub;

  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[1:0];

  // Largest payload that keeps this completion inside MPS and ends
  // it on an RCB boundary when it is not the last one.
  function automatic logic [10:0] chunk_of(
    input logic [4:0]  cur_lo,
    input logic [10:0] rem
  );
    logic [10:0] max_dw;
    max_dw = MPS_DW - {6'd0, cur_lo & RCB_MASK};
    return (rem <= max_dw) ? rem : max_dw;
  endfunction

  // ---------------- FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- FSM: next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req_valid) state_nxt = CALC;
      end
      CALC: begin
        state_nxt = EMIT;
      end
      EMIT: begin
        if (cpl_ready && cpl_last) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------- FSM: outputs
  always_comb begin
    req_ready = (state == IDLE);
    cpl_valid = (state == EMIT);
    busy      = (state != IDLE);
  end

  // ---------------- request byte-count decode
  always_comb begin
    casez (a_fbe)
      4'b???1: fo_c = 2'd0;
      4'b??10: fo_c = 2'd1;
      4'b?100: fo_c = 2'd2;
      default: fo_c = 2'd3;
    endcase
  end

  always_comb begin
    casez (a_lbe)
      4'b1???: lt_c = 2'd0;
      4'b01??: lt_c = 2'd1;
      4'b001?: lt_c = 2'd2;
      default: lt_c = 2'd3;
    endcase
  end

  assign len_dw = (a_len == 10'd0) ? 11'd1024 : {1'b0, a_len};

  // Single-DW reads count the span of enabled bytes, holes included.
  always_comb begin
    tb_c = 13'd0;
    if (a_len == 10'd1) begin
      casez (a_fbe)
        4'b1??1: tb_c = 13'd4;
        4'b01?1: tb_c = 13'd3;
        4'b1?10: tb_c = 13'd3;
        4'b0011: tb_c = 13'd2;
        4'b0110: tb_c = 13'd2;
        4'b1100: tb_c = 13'd2;
        default: tb_c = 13'd1;
      endcase
    end else begin
      tb_c = {len_dw, 2'b00} - {11'd0, fo_c}
           - {11'd0, lt_c};
    end
  end

  assign chunk0 = chunk_of(a_dw[4:0], len_dw);

  // ---------------- next chunk
  // Only the first completion starts mid-DW, so only it gives
  // back the leading disabled bytes.
  assign n_sub   = {chunk_r, 2'b00}
                 - (first ? {11'd0, fo_r} : 13'd0);
  assign n_cur   = cur_dw + {51'd0, chunk_r};
  assign n_rem   = rem_dw - chunk_r;
  assign n_rb    = rb - n_sub;
  assign n_off   = off_dw + chunk_r[9:0];
  assign n_chunk = chunk_of(n_cur[4:0], n_rem);

  // ---------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_dw             <= '0;
      a_len            <= '0;
      a_fbe            <= '0;
      a_lbe            <= '0;
      cur_dw           <= '0;
      rem_dw           <= '0;
      rb               <= '0;
      off_dw           <= '0;
      chunk_r          <= '0;
      fo_r             <= '0;
      first            <= 1'b0;
      cpl_length       <= '0;
      cpl_byte_cnt     <= '0;
      cpl_lower_addr   <= '0;
      cpl_dw_offset    <= '0;
      cpl_tag          <= '0;
      cpl_requester_id <= '0;
      cpl_tc           <= '0;
      cpl_attr         <= '0;
      cpl_last         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            a_dw             <= req_addr[63:2];
            a_len            <= req_length;
            a_fbe            <= req_first_be;
            a_lbe            <= req_last_be;
            cpl_tag          <= req_tag;
            cpl_requester_id <= req_requester_id;
            cpl_tc           <= req_tc;
            cpl_attr         <= req_attr;
          end
        end
        CALC: begin
          cur_dw         <= a_dw;
          rem_dw         <= len_dw;
          rb             <= tb_c;
          off_dw         <= '0;
          chunk_r        <= chunk0;
          fo_r           <= fo_c;
          first          <= 1'b1;
          cpl_length     <= chunk0[9:0];
          cpl_byte_cnt   <= tb_c[11:0];
          cpl_lower_addr <= {a_dw[4:0], fo_c};
          cpl_dw_offset  <= '0;
          cpl_last       <= (chunk0 == len_dw);
        end
        EMIT: begin
          if (cpl_ready && !cpl_last) begin
            cur_dw         <= n_cur;
            rem_dw         <= n_rem;
            rb             <= n_rb;
            off_dw         <= n_off;
            chunk_r        <= n_chunk;
            first          <= 1'b0;
            cpl_length     <= n_chunk[9:0];
            cpl_byte_cnt   <= n_rb[11:0];
            cpl_lower_addr <= {n_cur[4:0], 2'b00};
            cpl_dw_offset  <= n_off;
            cpl_last       <= (n_chunk == n_rem);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_tl_cpl_splitter.sv
// tb_pcie_tl_cpl_splitter: table-driven requests with a completion
// scoreboard, plus backpressure and mid-request reset sequences.

module tb_pcie_tl_cpl_splitter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [9:0]  req_length;
  logic [3:0]  req_first_be;
  logic [3:0]  req_last_be;
  logic [9:0]  req_tag;
  logic [15:0] req_requester_id;
  logic [2:0]  req_tc;
  logic [2:0]  req_attr;
  logic        cpl_valid;
  logic        cpl_ready;
  logic [9:0]  cpl_length;
  logic [11:0] cpl_byte_cnt;
  logic [6:0]  cpl_lower_addr;
  logic [9:0]  cpl_dw_offset;
  logic [9:0]  cpl_tag;
  logic [15:0] cpl_requester_id;
  logic [2:0]  cpl_tc;
  logic [2:0]  cpl_attr;
  logic        cpl_last;
  logic        busy;

  pcie_tl_cpl_splitter #(
    .MPS_BYTES(256),
    .RCB_BYTES(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_length(req_length),
    .req_first_be(req_first_be),
    .req_last_be(req_last_be),
    .req_tag(req_tag),
    .req_requester_id(req_requester_id),
    .req_tc(req_tc),
    .req_attr(req_attr),
    .cpl_valid(cpl_valid),
    .cpl_ready(cpl_ready),
    .cpl_length(cpl_length),
    .cpl_byte_cnt(cpl_byte_cnt),
    .cpl_lower_addr(cpl_lower_addr),
    .cpl_dw_offset(cpl_dw_offset),
    .cpl_tag(cpl_tag),
    .cpl_requester_id(cpl_requester_id),
    .cpl_tc(cpl_tc),
    .cpl_attr(cpl_attr),
    .cpl_last(cpl_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  len;
    logic [11:0] bc;
    logic [6:0]  la;
    logic [9:0]  off;
    logic [9:0]  tag;
    logic [15:0] rid;
    logic [2:0]  tc;
    logic [2:0]  attr;
    logic        last;
  } cpl_t;

  typedef struct {
    logic [63:0] addr;
    logic [9:0]  len;
    logic [3:0]  fbe;
    logic [3:0]  lbe;
    logic [9:0]  tag;
    logic [15:0] rid;
    logic [2:0]  tc;
    logic [2:0]  attr;
    int          first;
    int          n;
  } vec_t;

  vec_t vt[$];
  cpl_t et[$];
  cpl_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [71:0] snap();
    return {cpl_length, cpl_byte_cnt, cpl_lower_addr,
            cpl_dw_offset, cpl_tag, cpl_requester_id,
            cpl_tc, cpl_attr, cpl_last};
  endfunction

  task automatic chk(input string nm,
                     input logic [71:0] got,
                     input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic add_vec(input logic [63:0] a,
                         input logic [9:0] l,
                         input logic [3:0] f,
                         input logic [3:0] b,
                         input logic [9:0] t,
                         input logic [15:0] r,
                         input logic [2:0] c,
                         input logic [2:0] at);
    vec_t v;
    v.addr = a; v.len = l; v.fbe = f; v.lbe = b;
    v.tag = t; v.rid = r; v.tc = c; v.attr = at;
    v.first = et.size();
    v.n = 0;
    vt.push_back(v);
  endtask

  task automatic add_cpl(input logic [9:0] l,
                         input logic [11:0] bc,
                         input logic [6:0] la,
                         input logic [9:0] off,
                         input logic last);
    vec_t v;
    cpl_t c;
    v = vt[vt.size()-1];
    c.len = l; c.bc = bc; c.la = la; c.off = off;
    c.tag = v.tag; c.rid = v.rid; c.tc = v.tc;
    c.attr = v.attr; c.last = last;
    et.push_back(c);
    v.n++;
    vt[vt.size()-1] = v;
  endtask

  task automatic drive(input vec_t v);
    req_addr = v.addr;
    req_length = v.len;
    req_first_be = v.fbe;
    req_last_be = v.lbe;
    req_tag = v.tag;
    req_requester_id = v.rid;
    req_tc = v.tc;
    req_attr = v.attr;
  endtask

  // starts and ends at a negedge
  task automatic send_req(input int i);
    vec_t v;
    int k;
    v = vt[i];
    k = 0;
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("req_ready", 72'(req_ready), 72'd1);
    if (!req_ready) return;
    drive(v);
    req_valid = 1'b1;
    @(posedge clk);
    for (int j = 0; j < v.n; j++) sb.push_back(et[v.first + j]);
    @(negedge clk);
    req_valid = 1'b0;
    chk("calc_cycle", 72'({cpl_valid, busy}), 72'b01);
    @(negedge clk);
    chk("latency", 72'(cpl_valid), 72'd1);
  endtask

  // starts and ends at a negedge
  task automatic take_cpl(input int stall, input bit pulse);
    int k;
    cpl_t e;
    logic [71:0] s0;
    k = 0;
    while (!cpl_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!cpl_valid) begin
      chk("cpl_timeout", 72'(cpl_valid), 72'd1);
      return;
    end
    if (stall > 0) begin
      cpl_ready = 1'b0;
      s0 = snap();
      for (int c = 0; c < stall; c++) begin
        if (pulse && c == 0) begin
          drive(vt[0]);
          req_valid = 1'b1;
          chk("busy_req_ready", 72'(req_ready), 72'd0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp_valid", 72'(cpl_valid), 72'd1);
        chk("bp_hold", snap(), s0);
      end
      cpl_ready = 1'b1;
    end
    if (sb.size() == 0) begin
      chk("unexpected_cpl", 72'(cpl_valid), 72'd0);
    end else begin
      e = sb.pop_front();
      chk("cpl", snap(), 72'(e));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_idle(input string nm);
    chk(nm, 72'({req_ready, cpl_valid, busy}), 72'b100);
  endtask

  initial begin
    // addr, len, fbe, lbe, tag, rid, tc, attr
    add_vec(64'h1000, 10'd1, 4'hF, 4'h0,
            10'h011, 16'hABCD, 3'd0, 3'd0);
    add_cpl(10'd1, 12'd4, 7'h00, 10'd0, 1'b1);
    add_vec(64'h2004, 10'd1, 4'h6, 4'h0,
            10'h3FF, 16'h0102, 3'd7, 3'd5);
    add_cpl(10'd1, 12'd2, 7'h05, 10'd0, 1'b1);
    add_vec(64'h40, 10'd2, 4'hE, 4'h7,
            10'h155, 16'h8001, 3'd2, 3'd1);
    add_cpl(10'd2, 12'd6, 7'h41, 10'd0, 1'b1);
    add_vec(64'h7C, 10'd1, 4'h0, 4'h0,
            10'h001, 16'h0001, 3'd1, 3'd2);
    add_cpl(10'd1, 12'd1, 7'h7F, 10'd0, 1'b1);
    add_vec(64'h8, 10'd1, 4'hA, 4'h0,
            10'h002, 16'h0002, 3'd3, 3'd4);
    add_cpl(10'd1, 12'd3, 7'h09, 10'd0, 1'b1);
    // index 5: RCB/MPS split
    add_vec(64'h3010, 10'd128, 4'hF, 4'hF,
            10'h2AA, 16'h1234, 3'd4, 3'd6);
    add_cpl(10'd60, 12'd512, 7'h10, 10'd0, 1'b0);
    add_cpl(10'd64, 12'd272, 7'h00, 10'd60, 1'b0);
    add_cpl(10'd4, 12'd16, 7'h00, 10'd124, 1'b1);
    add_vec(64'h3F8, 10'd60, 4'hC, 4'h1,
            10'h0F0, 16'hBEEF, 3'd5, 3'd3);
    add_cpl(10'd50, 12'd235, 7'h7A, 10'd0, 1'b0);
    add_cpl(10'd10, 12'd37, 7'h40, 10'd50, 1'b1);
    add_vec(64'hDEAD_BEEF_0000_0104, 10'd3, 4'hF, 4'h3,
            10'h123, 16'h5A5A, 3'd6, 3'd7);
    add_cpl(10'd3, 12'd10, 7'h04, 10'd0, 1'b1);
    add_vec(64'h0, 10'd0, 4'hF, 4'hF,
            10'h0AA, 16'hC0DE, 3'd1, 3'd1);
    for (int i = 0; i < 16; i++)
      add_cpl(10'd64, 12'(4096 - 256 * i), 7'h00,
              10'(64 * i), (i == 15));

    rst = 1'b1;
    req_valid = 1'b0;
    cpl_ready = 1'b1;
    drive(vt[0]);
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", 72'(req_ready), 72'd1);
    chk("rst_cpl_valid", 72'(cpl_valid), 72'd0);
    chk("rst_busy", 72'(busy), 72'd0);
    chk("rst_data", snap(), 72'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vt.size(); i++) begin
      send_req(i);
      for (int j = 0; j < vt[i].n; j++) take_cpl(0, 1'b0);
      chk_idle("idle_after_req");
    end

    // backpressure on cpl2 with a request pulse while busy
    send_req(5);
    take_cpl(0, 1'b0);
    take_cpl(5, 1'b1);
    take_cpl(0, 1'b0);
    chk_idle("idle_after_bp");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("no_extra_req", 72'({cpl_valid, busy}), 72'b00);
    end

    // reset while cpl2 is on the outputs
    send_req(5);
    take_cpl(0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", 72'(cpl_valid), 72'd0);
    chk("rst_async_data", snap(), 72'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_idle("idle_after_rst");
    send_req(0);
    take_cpl(0, 1'b0);
    chk_idle("idle_after_final");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
